// File: rtl/count_expand.sv
// count_expand: turns a count into an LSB-first thermometer mask.
// The mask is built W bits per cycle to keep the per-cycle logic small.
//
// state  | meaning
// IDLE   | waiting for a count, in_ready high
// EXPAND | writing one W-bit chunk of the mask per cycle
// DONE   | mask complete, out_valid high until the consumer takes it
module count_expand #(
  parameter int N = 7,
  parameter int W = 2,
  localparam int K = $clog2(N + 1),
  localparam int C = (N + W - 1) / W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_mask,
  output logic         out_ovf
);

  localparam int IW = $clog2(C + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [K-1:0]   cnt;
  logic [IW-1:0]  idx;
  logic [N-1:0]   mask_nxt;
  logic           count_over;

  assign count_over = ({1'b0, in_count} > (K + 1)'(N));

  // State register; reset wins over everything, discarding any result in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, finish after chunk C-1, release on out_ready
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (in_valid)              state_nxt = S_EXPAND;
      S_EXPAND: if (idx == IW'(C - 1))     state_nxt = S_DONE;
      S_DONE:   if (out_ready)             state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded purely from the registered state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Next mask: only the bits belonging to chunk idx change; bits past N never exist
  always_comb begin
    mask_nxt = out_mask;
    for (int i = 0; i < N; i++) begin
      if (IW'(i / W) == idx) begin
        mask_nxt[i] = ((K + 1)'(i) < {1'b0, cnt});
      end
    end
  end

  // Datapath: latch saturated count on accept, then fill chunks while expanding
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      out_mask <= '0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt      <= count_over ? K'(N) : in_count;
            out_ovf  <= count_over;
            out_mask <= '0;
            idx      <= '0;
          end
        end
        S_EXPAND: begin
          out_mask <= mask_nxt;
          idx      <= idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_expand.sv
// Directed bench for count_expand: four N=7 instances with W = 2,1,3,7 and
// one N=5, W=2 instance for the saturating partial-last-chunk case.
module tb_count_expand;

  logic clk;
  logic rst;

  logic       iv   [4];
  logic       ir   [4];
  logic [2:0] ic   [4];
  logic       ov   [4];
  logic       orr  [4];
  logic [6:0] om   [4];
  logic       of_  [4];

  logic       iv5;
  logic       ir5;
  logic [2:0] ic5;
  logic       ov5;
  logic       orr5;
  logic [4:0] om5;
  logic       of5;

  int n_tests;
  int n_fail;

  logic [6:0] therm [8];
  int         exp_cyc [4];

  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int WV = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
    count_expand #(.N(7), .W(WV)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_count  (ic[g]),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .out_mask  (om[g]),
      .out_ovf   (of_[g])
    );
  end

  count_expand #(.N(5), .W(2)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv5),
    .in_ready  (ir5),
    .in_count  (ic5),
    .out_valid (ov5),
    .out_ready (orr5),
    .out_mask  (om5),
    .out_ovf   (of5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept count c on instance g and wait (bounded) for out_valid.
  task automatic start_tx(input int g, input logic [2:0] c, input logic hold_ready,
                          output int cyc);
    @(negedge clk);
    iv[g]  = 1'b1;
    ic[g]  = c;
    orr[g] = hold_ready;
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
    ic[g] = 3'd0;
    check_val("accept_clear", {25'd0, om[g]}, 32'd0);
    cyc = 0;
    while (!ov[g] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic finish_tx(input int g);
    orr[g] = 1'b1;
    @(posedge clk);
    #1;
    orr[g] = 1'b0;
    check_val("back_idle", {31'd0, ir[g]}, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [6:0] m;
    n_tests = 0;
    n_fail  = 0;
    therm = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F};
    exp_cyc = '{4, 7, 3, 1};
    for (int g = 0; g < 4; g++) begin
      iv[g] = 1'b0; ic[g] = 3'd0; orr[g] = 1'b0;
    end
    iv5 = 1'b0; ic5 = 3'd0; orr5 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_val("rst_in_ready", {31'd0, ir[0]}, 32'd1);
    check_val("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    check_val("rst_mask", {25'd0, om[0]}, 32'd0);
    check_val("rst_ovf", {31'd0, of_[0]}, 32'd0);

    // count 3, W=2: four cycles to out_valid
    start_tx(0, 3'd3, 1'b0, cyc);
    check_val("c3_cycles", cyc, 32'd4);
    check_val("c3_mask", {25'd0, om[0]}, 32'h07);
    check_val("c3_ovf", {31'd0, of_[0]}, 32'd0);
    finish_tx(0);
    check_val("c3_mask_kept", {25'd0, om[0]}, 32'h07);

    // extremes 0 and 7
    start_tx(0, 3'd0, 1'b0, cyc);
    check_val("c0_mask", {25'd0, om[0]}, 32'h00);
    check_val("c0_ovf", {31'd0, of_[0]}, 32'd0);
    finish_tx(0);
    start_tx(0, 3'd7, 1'b0, cyc);
    check_val("c7_mask", {25'd0, om[0]}, 32'h7F);
    check_val("c7_ovf", {31'd0, of_[0]}, 32'd0);
    finish_tx(0);

    // DONE held for 10 cycles with in_valid pulled high (must be ignored)
    start_tx(0, 3'd5, 1'b0, cyc);
    iv[0] = 1'b1;
    ic[0] = 3'd1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", {31'd0, ov[0]}, 32'd1);
      check_val("hold_ready", {31'd0, ir[0]}, 32'd0);
      check_val("hold_mask", {25'd0, om[0]}, 32'h1F);
    end
    iv[0] = 1'b0;
    ic[0] = 3'd0;
    finish_tx(0);
    check_val("hold_after", {31'd0, ov[0]}, 32'd0);

    // out_ready held high through EXPAND: must not shorten the expansion
    start_tx(0, 3'd2, 1'b1, cyc);
    check_val("rdy_early_cycles", cyc, 32'd4);
    check_val("rdy_early_mask", {25'd0, om[0]}, 32'h03);
    @(posedge clk);
    #1;
    orr[0] = 1'b0;
    check_val("rdy_early_idle", {31'd0, ir[0]}, 32'd1);

    // reset in EXPAND after two chunks
    @(negedge clk);
    iv[0] = 1'b1;
    ic[0] = 3'd7;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("mid_mask", {25'd0, om[0]}, 32'h0F);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("mid_rst_ready", {31'd0, ir[0]}, 32'd1);
    check_val("mid_rst_valid", {31'd0, ov[0]}, 32'd0);
    check_val("mid_rst_mask", {25'd0, om[0]}, 32'd0);

    // every count through every chunk width
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 8; c++) begin
        start_tx(g, 3'(c), 1'b0, cyc);
        check_val($sformatf("w%0d_c%0d_cyc", g, c), cyc, exp_cyc[g]);
        check_val($sformatf("w%0d_c%0d_mask", g, c), {25'd0, om[g]}, {25'd0, therm[c]});
        finish_tx(g);
      end
    end

    // a few random counts on W=3
    for (int r = 0; r < 4; r++) begin
      int c;
      c = $urandom_range(0, 7);
      start_tx(2, 3'(c), 1'b0, cyc);
      m = om[2];
      check_val("rnd_cyc", cyc, 32'd3);
      check_val("rnd_pop", $countones(m), c);
      check_val("rnd_mask", {25'd0, m}, {25'd0, therm[c]});
      finish_tx(2);
    end

    // N=5: count 6 saturates, partial last chunk
    @(negedge clk);
    iv5 = 1'b1;
    ic5 = 3'd6;
    @(posedge clk);
    #1;
    iv5 = 1'b0;
    cyc = 0;
    while (!ov5 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("n5_cycles", cyc, 32'd3);
    check_val("n5_mask", {27'd0, om5}, 32'h1F);
    check_val("n5_ovf", {31'd0, of5}, 32'd1);
    orr5 = 1'b1;
    @(posedge clk);
    #1;
    orr5 = 1'b0;
    check_val("n5_idle", {31'd0, ir5}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
